recirc_demux_param: RTL and testbench

RECIRC_DEMUX_PARAM -- requirements
Module: recirc_demux_param

---
 rtl/recirc_demux_param.sv | 154 +++++++++++++++
 tb/tb_recirc_demux_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/recirc_demux_param.sv
// rtl/recirc_demux_param.sv - recirculate-then-demux lane router with per-lane A/B toggles
module recirc_demux_param #(
    parameter int LANES       = 4,
    parameter int DATA_W      = 8,
    parameter int RECIRC_LEN  = 4,
    parameter int IDLE_THRESH = 2
) (
    input  logic                      clk_f,
    input  logic                      reset,
    input  logic [LANES*DATA_W-1:0]   data_in,
    input  logic [LANES-1:0]          valid_in,
    output logic [LANES*DATA_W-1:0]   data_r,
    output logic [LANES-1:0]          valid_r,
    output logic [LANES*DATA_W-1:0]   data_a,
    output logic [LANES*DATA_W-1:0]   data_b,
    output logic [LANES-1:0]          valid_a,
    output logic [LANES-1:0]          valid_b,
    output logic                      idle_out,
    output logic                      active_out
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_RECIRC = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    localparam logic [7:0] RECIRC_LAST = 8'(RECIRC_LEN - 1);
    localparam logic [8:0] QUIET_LIMIT = 9'(IDLE_THRESH);

    state_t                    state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [7:0]                quiet_q, quiet_d;
    logic [LANES-1:0]          tog_q, tog_d;
    logic [LANES*DATA_W-1:0]   data_r_q, data_r_d;
    logic [LANES-1:0]          valid_r_q, valid_r_d;
    logic [LANES*DATA_W-1:0]   data_a_q, data_a_d;
    logic [LANES*DATA_W-1:0]   data_b_q, data_b_d;
    logic [LANES-1:0]          valid_a_q, valid_a_d;
    logic [LANES-1:0]          valid_b_q, valid_b_d;
    logic                      idle_q, active_q;
    logic                      demux;

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            quiet_q   <= '0;
            tog_q     <= '0;
            data_r_q  <= '0;
            valid_r_q <= '0;
            data_a_q  <= '0;
            data_b_q  <= '0;
            valid_a_q <= '0;
            valid_b_q <= '0;
            idle_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quiet_q   <= quiet_d;
            tog_q     <= tog_d;
            data_r_q  <= data_r_d;
            valid_r_q <= valid_r_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            valid_a_q <= valid_a_d;
            valid_b_q <= valid_b_d;
            idle_q    <= (state_d == ST_IDLE);
            active_q  <= (state_d == ST_ACTIVE);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quiet_d   = quiet_q;
        tog_d     = tog_q;
        data_r_d  = data_r_q;
        valid_r_d = '0;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        valid_a_d = '0;
        valid_b_d = '0;
        demux     = 1'b0;

        case (state_q)
            ST_RESET: begin
                state_d = ST_RECIRC;
                cnt_d   = '0;
                tog_d   = '0;
            end
            ST_RECIRC: begin
                data_r_d  = data_in;
                valid_r_d = valid_in;
                data_a_d  = '0;
                data_b_d  = '0;
                tog_d     = '0;
                if (cnt_q == RECIRC_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_IDLE: begin
                // The waking word is routed in the same cycle so nothing is lost on entry.
                if (|valid_in) begin
                    demux   = 1'b1;
                    state_d = ST_ACTIVE;
                    quiet_d = '0;
                end
            end
            ST_ACTIVE: begin
                demux = 1'b1;
                if (|valid_in) begin
                    quiet_d = '0;
                end else if (({1'b0, quiet_q} + 9'd1) == QUIET_LIMIT) begin
                    state_d = ST_IDLE;
                    quiet_d = '0;
                end else begin
                    quiet_d = quiet_q + 8'd1;
                end
            end
            default: state_d = ST_RESET;
        endcase

        if (demux) begin
            for (int k = 0; k < LANES; k++) begin
                if (valid_in[k]) begin
                    if (tog_q[k]) begin
                        data_b_d[k*DATA_W +: DATA_W] = data_in[k*DATA_W +: DATA_W];
                        valid_b_d[k]                 = 1'b1;
                    end else begin
                        data_a_d[k*DATA_W +: DATA_W] = data_in[k*DATA_W +: DATA_W];
                        valid_a_d[k]                 = 1'b1;
                    end
                    tog_d[k] = ~tog_q[k];
                end
            end
        end
    end

    assign data_r     = data_r_q;
    assign valid_r    = valid_r_q;
    assign data_a     = data_a_q;
    assign data_b     = data_b_q;
    assign valid_a    = valid_a_q;
    assign valid_b    = valid_b_q;
    assign idle_out   = idle_q;
    assign active_out = active_q;

endmodule

// File: tb/tb_recirc_demux_param.sv
// tb/tb_recirc_demux_param.sv - directed and randomized checks of recirc_demux_param (default and 8x16 builds)
module tb_recirc_demux_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [31:0]  din0;
    logic [3:0]   vin0;
    logic [31:0]  dr0, da0, db0;
    logic [3:0]   vr0, va0, vb0;
    logic         idle0, act0;
    logic [127:0] din1;
    logic [7:0]   vin1;
    logic [127:0] dr1, da1, db1;
    logic [7:0]   vr1, va1, vb1;
    logic         idle1, act1;

    recirc_demux_param dut0 (
        .clk_f(clk), .reset(rst_n), .data_in(din0), .valid_in(vin0),
        .data_r(dr0), .valid_r(vr0), .data_a(da0), .data_b(db0),
        .valid_a(va0), .valid_b(vb0), .idle_out(idle0), .active_out(act0)
    );

    recirc_demux_param #(.LANES(8), .DATA_W(16), .RECIRC_LEN(1), .IDLE_THRESH(2)) dut1 (
        .clk_f(clk), .reset(rst_n), .data_in(din1), .valid_in(vin1),
        .data_r(dr1), .valid_r(vr1), .data_a(da1), .data_b(db1),
        .valid_a(va1), .valid_b(vb1), .idle_out(idle1), .active_out(act1)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode 0=reset 1=recirc 2=idle 3=active, one entry per build
    int           n_lanes [2] = '{4, 8};
    int           lane_w  [2] = '{8, 16};
    int           rlen    [2] = '{4, 1};
    int           thresh  [2] = '{2, 2};
    int           mode    [2];
    int           recirc_cycles [2];
    int           quiet_run [2];
    bit   [7:0]   tog     [2];
    logic [127:0] e_dr [2], e_da [2], e_db [2];
    logic [7:0]   e_vr [2], e_va [2], e_vb [2];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mode[d] = 0; recirc_cycles[d] = 0; quiet_run[d] = 0; tog[d] = '0;
            e_dr[d] = '0; e_da[d] = '0; e_db[d] = '0;
            e_vr[d] = '0; e_va[d] = '0; e_vb[d] = '0;
        end
    endtask

    task automatic model_step(input int d);
        logic [127:0] din, mask, word;
        logic [7:0]   vin;
        din  = (d == 0) ? 128'(din0) : din1;
        vin  = (d == 0) ? 8'(vin0) : vin1;
        mask = (128'd1 << lane_w[d]) - 128'd1;
        e_vr[d] = '0; e_va[d] = '0; e_vb[d] = '0;
        if (mode[d] == 0) begin
            mode[d] = 1; recirc_cycles[d] = 0; tog[d] = '0;
        end else if (mode[d] == 1) begin
            e_dr[d] = din; e_vr[d] = vin; e_da[d] = '0; e_db[d] = '0; tog[d] = '0;
            recirc_cycles[d]++;
            if (recirc_cycles[d] == rlen[d]) mode[d] = 2;
        end else begin
            if (mode[d] == 3 || vin != 0) begin
                for (int k = 0; k < n_lanes[d]; k++) begin
                    if (vin[k]) begin
                        word = (din >> (k * lane_w[d])) & mask;
                        if (tog[d][k] == 1'b0) begin
                            e_da[d] = (e_da[d] & ~(mask << (k * lane_w[d]))) | (word << (k * lane_w[d]));
                            e_va[d][k] = 1'b1;
                        end else begin
                            e_db[d] = (e_db[d] & ~(mask << (k * lane_w[d]))) | (word << (k * lane_w[d]));
                            e_vb[d][k] = 1'b1;
                        end
                        tog[d][k] = ~tog[d][k];
                    end
                end
            end
            if (vin != 0) begin
                mode[d] = 3; quiet_run[d] = 0;
            end else if (mode[d] == 3) begin
                quiet_run[d]++;
                if (quiet_run[d] == thresh[d]) begin
                    mode[d] = 2; quiet_run[d] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("d0_data_r",  128'(dr0), e_dr[0]);
        check("d0_valid_r", 128'(vr0), 128'(e_vr[0]));
        check("d0_data_a",  128'(da0), e_da[0]);
        check("d0_data_b",  128'(db0), e_db[0]);
        check("d0_valid_a", 128'(va0), 128'(e_va[0]));
        check("d0_valid_b", 128'(vb0), 128'(e_vb[0]));
        check("d0_idle",    128'(idle0), 128'(mode[0] == 2));
        check("d0_active",  128'(act0),  128'(mode[0] == 3));
        check("d1_data_r",  dr1, e_dr[1]);
        check("d1_valid_r", 128'(vr1), 128'(e_vr[1]));
        check("d1_data_a",  da1, e_da[1]);
        check("d1_data_b",  db1, e_db[1]);
        check("d1_valid_a", 128'(va1), 128'(e_va[1]));
        check("d1_valid_b", 128'(vb1), 128'(e_vb[1]));
        check("d1_idle",    128'(idle1), 128'(mode[1] == 2));
        check("d1_active",  128'(act1),  128'(mode[1] == 3));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic randomize_inputs();
        din0 = $urandom;
        vin0 = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom);
        din1 = {$urandom, $urandom, $urandom, $urandom};
        vin1 = ($urandom_range(0, 9) < 4) ? 8'h00 : 8'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        din0 = 32'hffeeddcc; vin0 = 4'hf;
        din1 = '0; vin1 = '0;
        model_reset();
        repeat (20) cyc();
        check("reset_valid_r", 128'(vr0), 128'd0);
        check("reset_idle",    128'(idle0), 128'd0);

        // Release: RESET->RECIRC, then 4 recirculated cycles before IDLE
        rst_n = 1'b1;
        cyc();
        check("rel1_valid_r", 128'(vr0), 128'd0);
        cyc();
        check("rel2_valid_r", 128'(vr0), 128'hf);
        check("rel2_data_r",  128'(dr0), 128'hffeeddcc);
        check("rlen1_idle",   128'(idle1), 128'd1);
        cyc(); cyc();
        check("rel4_idle", 128'(idle0), 128'd0);
        cyc();
        check("rel5_idle", 128'(idle0), 128'd1);
        check("rel5_valid_r", 128'(vr0), 128'hf);

        vin0 = 4'h0;
        cyc();
        check("idle_valid_r", 128'(vr0), 128'd0);
        check("idle_data_r_hold", 128'(dr0), 128'hffeeddcc);

        din0 = 32'hbbaa9988; vin0 = 4'hf;
        cyc();
        check("w1_valid_a", 128'(va0), 128'hf);
        check("w1_data_a",  128'(da0), 128'hbbaa9988);
        check("w1_active",  128'(act0), 128'd1);
        din0 = 32'h77665544;
        cyc();
        check("w2_valid_b", 128'(vb0), 128'hf);
        check("w2_valid_a", 128'(va0), 128'h0);
        check("w2_data_b",  128'(db0), 128'h77665544);

        din0 = 32'h00007700; vin0 = 4'h2;
        cyc();
        check("lane1_valid_a", 128'(va0), 128'h2);
        check("lane1_valid_b", 128'(vb0), 128'h0);
        check("lane1_data_a",  128'(da0), 128'hbbaa7788);

        vin0 = 4'h0; cyc();
        vin0 = 4'hf; cyc();
        check("quiet1_active", 128'(act0), 128'd1);
        vin0 = 4'h0; cyc();
        check("quiet_a_idle", 128'(idle0), 128'd0);
        cyc();
        check("quiet_b_idle", 128'(idle0), 128'd1);
        check("quiet_b_active", 128'(act0), 128'd0);

        repeat (300) begin
            randomize_inputs();
            cyc();
        end

        // Asynchronous reset in ACTIVE with words in flight
        din0 = 32'h12345678; vin0 = 4'hf;
        cyc();
        @(posedge clk);
        model_step(0); model_step(1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_valid_a", 128'(va0), 128'd0);
        check("async_valid_b", 128'(vb0), 128'd0);
        check("async_data_a",  128'(da0), 128'd0);
        check("async_active",  128'(act0), 128'd0);
        check("async_data_r1", dr1, 128'd0);
        repeat (3) cyc();
        rst_n = 1'b1;
        vin0 = 4'h0; vin1 = '0;
        repeat (5) cyc();
        check("rerun_idle", 128'(idle0), 128'd1);
        din0 = 32'hcafef00d; vin0 = 4'hf;
        cyc();
        check("rerun_port_a", 128'(va0), 128'hf);
        check("rerun_data_a", 128'(da0), 128'hcafef00d);

        repeat (300) begin
            randomize_inputs();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
